mmss_downcnt: RTL and testbench
===============================

# mmss_downcnt

Countdown timer core for the clock24 design: a four-digit BCD MM:SS register that counts down on a 1 Hz enable and flags expiry. It counts in the opposite direction to the minute/hour up-counters: it borrows where they carry, wraps 00 to 59 instead of 59 to 00, and emits a borrow-out pulse where they emit carry-out. It sits beside the clock chain, shares the same prescaled 1 Hz EN tick and debounced button pulses, and drives the same 7-segment mux.

## Interface
- ALARM_SEC, default 10: length of the alarm phase, in EN ticks. Legal range is 1 or more.
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- EN  in  1  1 Hz tick, one CLK wide.
- START  in  1  start/pause button pulse, one CLK wide.
- CLR  in  1  clear button pulse, one CLK wide.
- MINUP  in  1  minute-adjust pulse.
- SECUP  in  1  second-adjust pulse.
- SL  out  4  seconds low digit, BCD 0–9.
- SH  out  3  seconds high digit, 0–5.
- ML  out  4  minutes low digit, BCD 0–9.
- MH  out  3  minutes high digit, 0–5.
- RUNNING  out  1  high while in state RUN.
- ALARM  out  1  high while in state ALARM.
- BO  out  1  borrow-out (expiry strobe), combinational.

## Operation
- Reset behaviour:
  - All digits are 0 and the state is IDLE.
  - RUNNING=0, ALARM=0, BO=0.
  - The alarm tick counter is 0.
- States: IDLE, RUN, ALARM. Input priority in every state: CLR first, then START, then EN/MINUP/SECUP.
- IDLE (stopped and editable):
  - CLR sets the time to 00:00.
  - START moves to RUN if the time is not 00:00. If the time is 00:00, START is ignored.
  - MINUP increments minutes. ML wraps 9 to 0 with a carry into MH; 59 wraps to 00.
  - SECUP increments seconds the same way (59 wraps to 00) and never carries into minutes.
  - MINUP and SECUP together: both fields increment.
  - EN is ignored.
- RUN:
  - On EN, the time decrements by one second:
    - SL 0 becomes 9 with a borrow into SH.
    - SH=0 with SL=0 becomes 59 with a borrow into minutes.
    - ML 0 becomes 9 with a borrow into MH.
  - On EN with the time at 00:01, the time becomes 00:00 and the state moves to ALARM.
  - START moves to IDLE (pause). The time is held and no decrement happens, even if EN arrives in the same cycle.
  - CLR moves to IDLE and sets the time to 00:00.
  - MINUP and SECUP are ignored.
- ALARM:
  - The time holds at 00:00.
  - The tick counter is cleared on entry and increments on each EN.
  - On EN with the counter at ALARM_SEC-1, the state moves to IDLE.
  - START or CLR moves to IDLE immediately.
  - The tick counter width is clog2(ALARM_SEC+1).
- BO = (state==RUN) & EN & (time==00:01) & ~START & ~CLR.
- The digits never hold illegal values: SL and ML stay in 0–9, SH and MH stay in 0–5.

## Timing
- All digits, RUNNING and ALARM are registered. They update on the CLK edge that samples the causing input, so latency is one cycle.
- BO is combinational and is valid in the same cycle as the EN that causes the 00:01 to 00:00 transition. It is high for exactly one CLK.
- ALARM rises on the same edge where the time reaches 00:00. It stays high through exactly ALARM_SEC EN ticks if no button is pressed, then falls on the edge of the final tick.
- A START that pauses the count resumes counting from the held value. The first decrement comes on the next EN after the resume.
- Asserting RST mid-count or mid-alarm forces the reset state immediately, without waiting for CLK. Release is sampled on the next CLK.
- The inputs are assumed single-cycle pulses. A level held high on START re-toggles the state every cycle.

## Test plan
- Edit and start at 01:00:
  - Reset, then 1×MINUP, then START.
  - Required: RUNNING=1 on the next edge.
  - After 1 EN the time reads 00:59, with SH=5 and SL=9.
- Second wrap and zero start:
  - 60×SECUP from reset gives 00:00 with minutes still 00.
  - START at 00:00 leaves RUNNING=0.
- Expiry with ALARM_SEC=3:
  - Load 00:02 and START, then apply 2 EN.
  - Required: BO high during the second EN only, the time at 00:00, ALARM=1.
  - After 3 more EN: ALARM=0, state IDLE.
- Pause priority:
  - At 10:00 in RUN, assert START and EN in the same cycle.
  - Required: the time stays 10:00 and RUNNING=0.
  - A second START followed by 1 EN gives 09:59.
- Minute wrap and clear during RUN:
  - 59×MINUP then 1×MINUP gives 00:00.
  - Load 59:59 and START, then 1 EN gives 59:58.
  - CLR in the same cycle as EN gives 00:00 and IDLE, with BO=0.
- Asynchronous reset mid-alarm:
  - Assert RST between CLK edges while ALARM=1.
  - Required: ALARM, RUNNING and all digits go to 0 before the next edge.

Source files
------------

// File: rtl/mmss_downcnt.sv
// Four-digit BCD MM:SS countdown timer with edit, run and alarm phases.
// Counts down on the shared 1 Hz tick and strobes BO on expiry.
module mmss_downcnt #(
  parameter int ALARM_SEC = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_start,
  input  logic       i_clr,
  input  logic       i_minup,
  input  logic       i_secup,
  output logic [3:0] o_sl,
  output logic [2:0] o_sh,
  output logic [3:0] o_ml,
  output logic [2:0] o_mh,
  output logic       o_running,
  output logic       o_alarm,
  output logic       o_bo
);

  localparam int CW = $clog2(ALARM_SEC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_sl, r_ml;
  logic [2:0]    r_sh, r_mh;
  logic [3:0]    w_sl_next, w_ml_next;
  logic [2:0]    w_sh_next, w_mh_next;
  logic [3:0]    w_sl_inc, w_ml_inc, w_sl_dec, w_ml_dec;
  logic [2:0]    w_sh_inc, w_mh_inc, w_sh_dec, w_mh_dec;
  logic [CW-1:0] r_tick;
  logic          w_is_zero;
  logic          w_is_one;
  logic          w_last_tick;

  assign w_is_zero   = (r_sl == 4'd0) && (r_sh == 3'd0) && (r_ml == 4'd0) && (r_mh == 3'd0);
  assign w_is_one    = (r_sl == 4'd1) && (r_sh == 3'd0) && (r_ml == 4'd0) && (r_mh == 3'd0);
  assign w_last_tick = (r_tick == CW'(ALARM_SEC - 1));

  // Field increments wrap 59->00 independently; the decrement borrows through all four digits.
  always_comb begin
    w_sl_inc = r_sl + 4'd1;
    w_sh_inc = r_sh;
    if (r_sl == 4'd9) begin
      w_sl_inc = 4'd0;
      w_sh_inc = (r_sh == 3'd5) ? 3'd0 : r_sh + 3'd1;
    end
    w_ml_inc = r_ml + 4'd1;
    w_mh_inc = r_mh;
    if (r_ml == 4'd9) begin
      w_ml_inc = 4'd0;
      w_mh_inc = (r_mh == 3'd5) ? 3'd0 : r_mh + 3'd1;
    end
    w_sl_dec = (r_sl == 4'd0) ? 4'd9 : r_sl - 4'd1;
    w_sh_dec = r_sh;
    w_ml_dec = r_ml;
    w_mh_dec = r_mh;
    if (r_sl == 4'd0) begin
      w_sh_dec = (r_sh == 3'd0) ? 3'd5 : r_sh - 3'd1;
      if (r_sh == 3'd0) begin
        w_ml_dec = (r_ml == 4'd0) ? 4'd9 : r_ml - 4'd1;
        if (r_ml == 4'd0) begin
          w_mh_dec = (r_mh == 3'd0) ? 3'd5 : r_mh - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!i_clr && i_start && !w_is_zero) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (i_clr || i_start)     w_next_state = S_IDLE;
        else if (i_en && w_is_one) w_next_state = S_ALARM;
      end
      S_ALARM: begin
        if (i_clr || i_start)          w_next_state = S_IDLE;
        else if (i_en && w_last_tick) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // CLR beats START beats edits/ticks; START alone never changes the time.
  always_comb begin
    w_sl_next = r_sl;
    w_sh_next = r_sh;
    w_ml_next = r_ml;
    w_mh_next = r_mh;
    if (i_clr) begin
      w_sl_next = 4'd0;
      w_sh_next = 3'd0;
      w_ml_next = 4'd0;
      w_mh_next = 3'd0;
    end else if (!i_start) begin
      if (r_state == S_IDLE) begin
        if (i_minup) begin
          w_ml_next = w_ml_inc;
          w_mh_next = w_mh_inc;
        end
        if (i_secup) begin
          w_sl_next = w_sl_inc;
          w_sh_next = w_sh_inc;
        end
      end else if (r_state == S_RUN && i_en) begin
        w_sl_next = w_sl_dec;
        w_sh_next = w_sh_dec;
        w_ml_next = w_ml_dec;
        w_mh_next = w_mh_dec;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sl   <= 4'd0;
      r_sh   <= 3'd0;
      r_ml   <= 4'd0;
      r_mh   <= 3'd0;
      r_tick <= '0;
    end else begin
      r_sl <= w_sl_next;
      r_sh <= w_sh_next;
      r_ml <= w_ml_next;
      r_mh <= w_mh_next;
      if (r_state != S_ALARM) begin
        r_tick <= '0;
      end else if (i_en) begin
        r_tick <= r_tick + CW'(1);
      end
    end
  end

  always_comb begin
    o_sl      = r_sl;
    o_sh      = r_sh;
    o_ml      = r_ml;
    o_mh      = r_mh;
    o_running = (r_state == S_RUN);
    o_alarm   = (r_state == S_ALARM);
    o_bo      = (r_state == S_RUN) && i_en && w_is_one && !i_start && !i_clr;
  end

endmodule

// File: tb/tb_mmss_downcnt.sv
// Scoreboard bench for mmss_downcnt: a seconds-count reference model predicts each cycle,
// and a negedge monitor pops and compares against the DUT outputs.
module tb_mmss_downcnt;

  localparam int ALARM_SEC  = 3;
  localparam int MODE_IDLE  = 0;
  localparam int MODE_RUN   = 1;
  localparam int MODE_ALARM = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, start, clr, minup, secup;
  logic [3:0] sl, ml;
  logic [2:0] sh, mh;
  logic       running, alarm, bo;

  typedef struct {
    string       tag;
    logic [16:0] exp;
  } rec_t;

  rec_t  q[$];
  int    checksRun    = 0;
  int    checksPassed = 0;
  int    mMins, mSecs, mMode, mLeft;
  string curTag;

  mmss_downcnt #(.ALARM_SEC(ALARM_SEC)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_start  (start),
    .i_clr    (clr),
    .i_minup  (minup),
    .i_secup  (secup),
    .o_sl     (sl),
    .o_sh     (sh),
    .o_ml     (ml),
    .o_mh     (mh),
    .o_running(running),
    .o_alarm  (alarm),
    .o_bo     (bo)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] modelOut(input logic expBo);
    return {3'(mMins / 10), 4'(mMins % 10), 3'(mSecs / 10), 4'(mSecs % 10),
            (mMode == MODE_RUN), (mMode == MODE_ALARM), expBo};
  endfunction

  task automatic resetModel();
    mMins = 0;
    mSecs = 0;
    mMode = MODE_IDLE;
    mLeft = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [16:0] expv);
    logic [16:0] act;
    act = {mh, ml, sh, sl, running, alarm, bo};
    checksRun++;
    if (act === expv) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d%0d:%0d%0d run=%0b alarm=%0b bo=%0b, expected %0d%0d:%0d%0d run=%0b alarm=%0b bo=%0b",
               tag, act[16:14], act[13:10], act[9:7], act[6:3], act[2], act[1], act[0],
               expv[16:14], expv[13:10], expv[9:7], expv[6:3], expv[2], expv[1], expv[0]);
    end
  endtask

  // Drive one cycle of pulses, queue the expected view for this cycle, then advance the model.
  task automatic applyStimulus(input logic s, input logic c, input logic e,
                               input logic mu, input logic su);
    rec_t r;
    logic expBo;
    int   total;
    @(posedge clk);
    #1;
    start = s;
    clr   = c;
    en    = e;
    minup = mu;
    secup = su;
    total = mMins * 60 + mSecs;
    expBo = (mMode == MODE_RUN) && e && (total == 1) && !s && !c;
    r.tag = curTag;
    r.exp = modelOut(expBo);
    q.push_back(r);
    if (c) begin
      mMins = 0;
      mSecs = 0;
      mMode = MODE_IDLE;
    end else if (s) begin
      if (mMode == MODE_IDLE) begin
        if (total != 0) mMode = MODE_RUN;
      end else begin
        mMode = MODE_IDLE;
      end
    end else if (mMode == MODE_IDLE) begin
      if (mu) mMins = (mMins + 1) % 60;
      if (su) mSecs = (mSecs + 1) % 60;
    end else if (mMode == MODE_RUN) begin
      if (e) begin
        total = total - 1;
        mMins = total / 60;
        mSecs = total % 60;
        if (total == 0) begin
          mMode = MODE_ALARM;
          mLeft = ALARM_SEC;
        end
      end
    end else if (e) begin
      mLeft = mLeft - 1;
      if (mLeft == 0) mMode = MODE_IDLE;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r = q.pop_front();
        checkOutput(r.tag, r.exp);
      end
    end
  end

  initial begin : driver
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    minup = 1'b0;
    secup = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    curTag = "reset";
    idle(1);

    curTag = "edit_start_0100";
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    curTag = "sec_wrap_zero_start";
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    curTag = "expiry";
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < ALARM_SEC; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
    end

    curTag = "pause_priority";
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    curTag = "minute_wrap";
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    curTag = "clear_in_run";
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);

    curTag = "async_reset_alarm";
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    en = 1'b0;
    start = 1'b0;
    clr = 1'b0;
    minup = 1'b0;
    secup = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("pre_reset_alarm", modelOut(1'b0));
    rst = 1'b1;
    #1;
    resetModel();
    checkOutput("async_reset_clears", modelOut(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    curTag = "after_reset";
    idle(1);

    curTag = "random";
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checksRun++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
